traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//   Timed phase sequencer for a two-road intersection (road A, road B) with a pedestrian
//   walk phase. Adds min/max green timing, yellow and all-red clearance intervals, and
//   latched pedestrian requests. Drives the six lamp outputs and the walk lamp. Sits between
//   the sensor front-end (TA/TB, ped button) and the lamp drivers.
// PARAMETERS
//   CNT_W      5   phase timer width; every T_* must be <= 2**CNT_W-1
//   T_MIN_GRN  8   min green cycles before gap-out allowed (>=1)
//   T_MAX_GRN  20  max green cycles when competing demand exists (>=T_MIN_GRN)
//   T_YEL      3   yellow duration, cycles (>=1)
//   T_ALLRED   2   all-red clearance duration, cycles (>=1)
//   T_WALK     6   pedestrian walk duration, cycles (>=1)
// PORTS
//   clk      in   1  clock, all state on rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   TA       in   1  traffic present on road A (sync to clk)
//   TB       in   1  traffic present on road B (sync to clk)
//   ped_req  in   1  pedestrian request, single-cycle pulse or level
//   RA,YA,GA out  1  road A red/yellow/green
//   RB,YB,GB out  1  road B red/yellow/green
//   walk     out  1  pedestrian walk lamp
//   phase    out  3  current state code (debug/observability)
// BEHAVIOUR
//   States/codes: A_GRN=0, A_YEL=1, A_CLR=2, B_GRN=3, B_YEL=4, B_CLR=5, PED=6; code 7 unused -> A_GRN next edge.
//   Reset (async on rst_n=0): state=A_GRN, timer=0, ped_pend=0, nxt_b=1 -> GA=1,RB=1, others 0, phase=0.
//   Outputs are Moore, decoded from the state register; change on the same edge as state.
//     A_GRN:GA,RB  A_YEL:YA,RB  A_CLR/B_CLR/PED:RA,RB  B_GRN:RA,GB  B_YEL:RA,YB  PED: walk=1.
//   timer: cleared to 0 on every state change, else +1, saturates at 2**CNT_W-1 (no wrap).
//   "tick(N)" means timer==N-1: the state has been held N cycles; transition on that edge.
//   A_GRN: demB = TB|ped_pend.
//     -> A_YEL if demB & timer>=T_MIN_GRN-1 & !TA (gap-out)
//     -> A_YEL if demB & timer>=T_MAX_GRN-1 (max-out)
//     no demB: hold indefinitely (timer saturates). B_GRN symmetric with demA=TA|ped_pend.
//   A_YEL -> A_CLR on tick(T_YEL). A_CLR on tick(T_ALLRED): -> PED if ped_pend else B_GRN; nxt_b<=1.
//   B_YEL -> B_CLR on tick(T_YEL). B_CLR on tick(T_ALLRED): -> PED if ped_pend else A_GRN; nxt_b<=0.
//   PED on tick(T_WALK): -> B_GRN if nxt_b else A_GRN.
//   ped_pend: set when ped_req=1 and state!=PED; cleared on the edge entering PED.
//     ped_req on the same edge as PED entry: clear wins (request counts as served).
//     ped_req while in PED: ignored.
//   Simultaneous TA and TB in green: only the gap/max rules apply; the current road keeps
//     priority until max-out. Inputs are sampled only in green states; yellow/clear/PED
//     durations are fixed and not shortened or extended.
//   Never GA&GB, never any green during PED; all lamps one-hot per road.
//   rst_n assertion in any state (incl. mid-PED or yellow) forces the reset values immediately.
// TESTING (default parameters; cycle 0 = first edge after rst_n rises)
//   1 Idle: TA=0,TB=0,ped_req=0 for 60 cycles -> phase=0 throughout, GA=1,RB=1, walk=0.
//   2 Gap-out: TA=0,TB=1 from cycle 0 -> A_GRN held 8 cycles, YA=1 for 3, all-red 2, GB=1
//     from cycle 13; then TB=0,TA=1 -> B gaps out after its 8th green cycle.
//   3 Max-out: TA=1,TB=1 constant -> A_GRN 20, A_YEL 3, A_CLR 2, B_GRN 20, ... repeating;
//     period 50 cycles, GA&GB never both 1.
//   4 Ped: TA=1,TB=0, ped_req pulse at cycle 2 -> max-out at 20 cycles, yellow 3, clear 2,
//     walk=1 for exactly 6 cycles with RA=RB=1, then B_GRN; ped_pend=0 after PED entry.
//   5 Ped corners: ped_req held through PED -> no second walk; ped_req pulse on PED-entry
//     edge -> no repeat walk; ped_req pulse during A_YEL -> walk after A_CLR.
//   6 Reset mid-op: drop rst_n during YB=1 and during walk=1 -> outputs return to GA=1,RB=1,
//     walk=0, phase=0 without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Purpose: timed two-road intersection phase sequencer with pedestrian walk phase.
// Latency: lamps are Moore outputs of the state register, so they change on the same edge as the state.
// Backpressure: none; sensor and request inputs are level-sampled every cycle, and no flow control exists.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 5,
    parameter int T_MIN_GRN = 8,
    parameter int T_MAX_GRN = 20,
    parameter int T_YEL     = 3,
    parameter int T_ALLRED  = 2,
    parameter int T_WALK    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_req,
    output logic       RA,
    output logic       YA,
    output logic       GA,
    output logic       RB,
    output logic       YB,
    output logic       GB,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        A_CLR = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        B_CLR = 3'd5,
        PED   = 3'd6
    } state_t;

    // Timer compare points: "held N cycles" is timer == N-1.
    localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(T_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(T_MAX_GRN - 1);
    localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] CLR_L  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_L = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] SAT    = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic             ped_pend;
    logic             nxt_b;
    logic             nxt_b_nxt;
    logic             dem_a;
    logic             dem_b;
    logic             enter_ped;

    // The opposing road's demand includes a pending walk, so a lone button press ends a green.
    assign dem_a     = TA | ped_pend;
    assign dem_b     = TB | ped_pend;
    assign enter_ped = (state_nxt == PED) && (state != PED);
    assign phase     = state;

    // Next-state selection and Moore lamp decode.
    always_comb begin
        state_nxt = state;
        nxt_b_nxt = nxt_b;
        RA        = 1'b0;
        YA        = 1'b0;
        GA        = 1'b0;
        RB        = 1'b0;
        YB        = 1'b0;
        GB        = 1'b0;
        walk      = 1'b0;
        case (state)
            A_GRN: begin
                GA = 1'b1;
                RB = 1'b1;
                // Gap-out once min green is met and A is empty; max-out regardless of TA.
                if (dem_b && (((timer >= MIN_L) && !TA) || (timer >= MAX_L)))
                    state_nxt = A_YEL;
            end
            A_YEL: begin
                YA = 1'b1;
                RB = 1'b1;
                if (timer == YEL_L)
                    state_nxt = A_CLR;
            end
            A_CLR: begin
                RA = 1'b1;
                RB = 1'b1;
                if (timer == CLR_L) begin
                    state_nxt = ped_pend ? PED : B_GRN;
                    nxt_b_nxt = 1'b1;
                end
            end
            B_GRN: begin
                RA = 1'b1;
                GB = 1'b1;
                if (dem_a && (((timer >= MIN_L) && !TB) || (timer >= MAX_L)))
                    state_nxt = B_YEL;
            end
            B_YEL: begin
                RA = 1'b1;
                YB = 1'b1;
                if (timer == YEL_L)
                    state_nxt = B_CLR;
            end
            B_CLR: begin
                RA = 1'b1;
                RB = 1'b1;
                if (timer == CLR_L) begin
                    state_nxt = ped_pend ? PED : A_GRN;
                    nxt_b_nxt = 1'b0;
                end
            end
            PED: begin
                RA   = 1'b1;
                RB   = 1'b1;
                walk = 1'b1;
                // Resume with the road that was about to be served when the walk cut in.
                if (timer == WALK_L)
                    state_nxt = nxt_b ? B_GRN : A_GRN;
            end
            default: begin
                // Unused code: show all-red for the single cycle before recovering.
                RA        = 1'b1;
                RB        = 1'b1;
                state_nxt = A_GRN;
            end
        endcase
    end

    // State, phase timer, pending walk request, and next-road memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= A_GRN;
            timer    <= '0;
            ped_pend <= 1'b0;
            nxt_b    <= 1'b1;
        end else begin
            state <= state_nxt;
            nxt_b <= nxt_b_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (timer != SAT)
                timer <= timer + 1'b1;
            // Entering PED serves the request, even if the button is pressed on that edge.
            if (enter_ped)
                ped_pend <= 1'b0;
            else if (ped_req && (state != PED))
                ped_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose: self-checking bench for traffic_phase_scheduler using a cycle-count reference model.
// Latency: the model predicts the lamp state after each rising edge, and the bench samples 1 time unit later.
// Backpressure: not applicable; inputs are driven freely between edges.
module tb_traffic_phase_scheduler;

    localparam int T_MIN_GRN = 8;
    localparam int T_MAX_GRN = 20;
    localparam int T_YEL     = 3;
    localparam int T_ALLRED  = 2;
    localparam int T_WALK    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       TA = 1'b0;
    logic       TB = 1'b0;
    logic       ped_req = 1'b0;
    logic       RA, YA, GA, RB, YB, GB, walk;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number, edges spent in it, pending walk, and which road follows a walk.
    int m_ph;
    int m_cnt;
    bit m_ped;
    bit m_nxtb;
    int walk_cnt;
    int dut_prev;
    int n;
    int cnt;

    traffic_phase_scheduler dut (
        .clk(clk), .rst_n(rst_n), .TA(TA), .TB(TB), .ped_req(ped_req),
        .RA(RA), .YA(YA), .GA(GA), .RB(RB), .YB(YB), .GB(GB),
        .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // Lamp pattern {RA,YA,GA,RB,YB,GB,walk} for each phase.
    function automatic logic [6:0] lamps(input int ph);
        case (ph)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            3:       return 7'b1000010;
            4:       return 7'b1000100;
            6:       return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one edge, working in cycles held rather than in a timer value.
    task automatic model_step(input bit ta, input bit tb, input bit pr);
        int held;
        int nph;
        int dur[7];
        bit own;
        bit other;
        dur  = '{0, T_YEL, T_ALLRED, 0, T_YEL, T_ALLRED, T_WALK};
        held = m_cnt + 1;
        nph  = m_ph;
        if (m_ph == 0 || m_ph == 3) begin
            own   = (m_ph == 0) ? ta : tb;
            other = ((m_ph == 0) ? tb : ta) || m_ped;
            if (other && ((held >= T_MIN_GRN && !own) || held >= T_MAX_GRN))
                nph = m_ph + 1;
        end else if (held == dur[m_ph]) begin
            if (m_ph == 2 || m_ph == 5) begin
                nph    = m_ped ? 6 : ((m_ph == 2) ? 3 : 0);
                m_nxtb = (m_ph == 2);
            end else if (m_ph == 6) begin
                nph = m_nxtb ? 3 : 0;
            end else begin
                nph = m_ph + 1;
            end
        end
        if (nph == 6 && m_ph != 6)
            m_ped = 1'b0;
        else if (pr && m_ph != 6)
            m_ped = 1'b1;
        m_cnt = (nph != m_ph) ? 0 : m_cnt + 1;
        m_ph  = nph;
    endtask

    task automatic step();
        bit ta;
        bit tb;
        bit pr;
        ta       = TA;
        tb       = TB;
        pr       = ped_req;
        dut_prev = int'(phase);
        @(posedge clk);
        model_step(ta, tb, pr);
        #1;
        check("lamps_phase", {22'd0, RA, YA, GA, RB, YB, GB, walk, phase},
              {22'd0, lamps(m_ph), m_ph[2:0]});
        check("green_exclusive", {31'd0, (GA & GB) | (walk & (GA | GB))}, 32'd0);
        if (walk)
            walk_cnt++;
    endtask

    // Assert reset away from any edge, check the values at once, then release before a rising edge.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check(tag, {22'd0, RA, YA, GA, RB, YB, GB, walk, phase}, {22'd0, 7'b0011000, 3'd0});
        m_ph   = 0;
        m_cnt  = 0;
        m_ped  = 1'b0;
        m_nxtb = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: idle; A green holds, then saturated timer lets a new B demand gap out at once.
        do_reset("reset_state");
        cnt = 0;
        repeat (60) begin
            step();
            if (phase != 3'd0)
                cnt++;
        end
        check("idle_not_agrn", cnt, 0);
        TB = 1'b1;
        step();
        check("sat_gapout", {29'd0, phase}, 32'd1);

        // Test 2: gap-out on A, then on B.
        do_reset("reset_t2");
        TA = 1'b0;
        TB = 1'b1;
        n = 0;
        while (!GB && n < 40) begin
            step();
            n++;
        end
        check("t2_edges_to_gb", n, 13);
        TA = 1'b1;
        TB = 1'b0;
        n = 0;
        while (!YB && n < 40) begin
            step();
            n++;
        end
        check("t2_b_gap_edges", n, 8);

        // Test 3: both roads busy, so the cycle is all max-outs with a 50-cycle period.
        TA = 1'b1;
        TB = 1'b1;
        n = 0;
        while (phase != 3'd0 && n < 40) begin
            step();
            n++;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!(phase == 3'd0 && dut_prev != 0) && n < 120);
        check("t3_period", n, 50);

        // Test 4: a walk request forces A off at max green, followed by a 6-cycle walk and then B.
        do_reset("reset_t4");
        TA = 1'b1;
        TB = 1'b0;
        walk_cnt = 0;
        step();
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 3;
        while (!walk && n < 60) begin
            step();
            n++;
        end
        check("t4_edges_to_walk", n, 25);
        n = 0;
        while (walk && n < 20) begin
            step();
            n++;
        end
        check("t4_walk_len", walk_cnt, 6);
        check("t4_after_walk", {29'd0, phase}, 32'd3);

        // Test 5a: request held through the walk gives no second walk.
        ped_req = 1'b1;
        n = 0;
        while (!walk && n < 60) begin
            step();
            n++;
        end
        while (walk && n < 80) begin
            step();
            n++;
        end
        ped_req  = 1'b0;
        walk_cnt = 0;
        repeat (60) step();
        check("t5a_no_rewalk", walk_cnt, 0);

        // Test 5b: a press on the PED-entry edge counts as served.
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while (!(m_ph == 2 && m_cnt == T_ALLRED - 1) && n < 60) begin
            step();
            n++;
        end
        walk_cnt = 0;
        ped_req  = 1'b1;
        step();
        ped_req = 1'b0;
        check("t5b_enter_ped", {29'd0, phase}, 32'd6);
        repeat (80) step();
        check("t5b_single_walk", walk_cnt, 6);

        // Test 5c: a press during A yellow leads to a walk straight after A clear.
        TB = 1'b1;
        n = 0;
        while (phase != 3'd1 && n < 60) begin
            step();
            n++;
        end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while (phase != 3'd2 && n < 10) begin
            step();
            n++;
        end
        while (phase == 3'd2 && n < 20) begin
            step();
            n++;
        end
        check("t5c_walk_after_clr", {29'd0, phase}, 32'd6);

        // Test 6: reset asserted mid-yellow and mid-walk.
        TA = 1'b1;
        TB = 1'b1;
        n = 0;
        while (!YB && n < 80) begin
            step();
            n++;
        end
        check("t6_reached_yb", {31'd0, YB}, 32'd1);
        do_reset("reset_in_yellow");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while (!walk && n < 80) begin
            step();
            n++;
        end
        check("t6_reached_walk", {31'd0, walk}, 32'd1);
        do_reset("reset_in_walk");

        // Randomized traffic, with demand density varied per block and occasional resets.
        for (int blk = 0; blk < 15; blk++) begin
            int da;
            int db;
            da = $urandom_range(0, 100);
            db = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                TA      = ($urandom_range(0, 99) < da);
                TB      = ($urandom_range(0, 99) < db);
                ped_req = ($urandom_range(0, 99) < 3);
                step();
                if ($urandom_range(0, 399) == 0)
                    do_reset("reset_random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
